// File: rtl/i2c_regbank_arbiter_if.sv
// Signal bundle between the I2C slave application side, a local core requester
// and the single-port register bank served by i2c_regbank_arbiter.
interface i2c_regbank_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          i2c_rw;
  logic [AW-1:0] i2c_addr;
  logic          i2c_wen;
  logic [DW-1:0] i2c_wdata;
  logic          i2c_rdata_used;
  logic [DW-1:0] i2c_rdata;
  logic          i2c_rdata_valid;
  logic          wr_overrun;

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  i2c_rw, i2c_addr, i2c_wen, i2c_wdata, i2c_rdata_used,
    output i2c_rdata, i2c_rdata_valid, wr_overrun,
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment view (slave, core and bank models)
  modport master (
    output i2c_rw, i2c_addr, i2c_wen, i2c_wdata, i2c_rdata_used,
    input  i2c_rdata, i2c_rdata_valid, wr_overrun,
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/i2c_regbank_arbiter.sv
// Shares a single-port register bank between the I2C slave (queued writes plus a
// prefetched read byte for the current address) and a core port with a starvation limit.
module i2c_regbank_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  i2c_regbank_arbiter_if.slave bus
);

  localparam int unsigned   SCW        = 8;
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  typedef enum logic [1:0] {SRC_I2C_WR, SRC_I2C_PF, SRC_CORE_WR, SRC_CORE_RD} src_t;

  state_t         state;
  src_t           iss_src;
  logic           wr_pend;
  logic           pf_pend;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [AW-1:0]  last_addr;
  logic [SCW-1:0] starve_cnt;

  logic core_win_c;
  logic wr_win_c;
  logic pf_win_c;
  logic addr_chg_c;
  logic coh_c;
  logic load_c;

  // Slot decision and capture-side qualifiers, all from registered state
  always_comb begin
    core_win_c = 1'b0;
    wr_win_c   = 1'b0;
    pf_win_c   = 1'b0;
    if (state == IDLE) begin
      if (bus.core_req && (starve_cnt == STARVE_MAX)) core_win_c = 1'b1;
      else if (wr_pend)                               wr_win_c   = 1'b1;
      else if (pf_pend)                               pf_win_c   = 1'b1;
      else if (bus.core_req)                          core_win_c = 1'b1;
    end
    addr_chg_c = (bus.i2c_addr != last_addr);
    coh_c      = (state == ISSUE) && (iss_src == SRC_I2C_WR) && (bus.mem_addr == last_addr);
    load_c     = (state == CAPTURE) && (iss_src == SRC_I2C_PF) &&
                 (bus.mem_addr == last_addr) && !pf_pend;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= IDLE;
      iss_src             <= SRC_I2C_WR;
      wr_pend             <= 1'b0;
      pf_pend             <= 1'b1;
      wr_addr             <= '0;
      wr_data             <= '0;
      last_addr           <= '0;
      starve_cnt          <= '0;
      bus.i2c_rdata       <= '0;
      bus.i2c_rdata_valid <= 1'b0;
      bus.wr_overrun      <= 1'b0;
      bus.core_gnt        <= 1'b0;
      bus.core_rvalid     <= 1'b0;
      bus.core_rdata      <= '0;
      bus.mem_en          <= 1'b0;
      bus.mem_we          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
    end else begin
      bus.mem_en      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.core_gnt    <= 1'b0;
      bus.core_rvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (core_win_c) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.core_we;
            bus.mem_addr  <= bus.core_addr;
            bus.mem_wdata <= bus.core_wdata;
            bus.core_gnt  <= 1'b1;
            iss_src       <= bus.core_we ? SRC_CORE_WR : SRC_CORE_RD;
            state         <= ISSUE;
          end else if (wr_win_c) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wr_addr;
            bus.mem_wdata <= wr_data;
            iss_src       <= SRC_I2C_WR;
            state         <= ISSUE;
          end else if (pf_win_c) begin
            bus.mem_en    <= 1'b1;
            bus.mem_addr  <= last_addr;
            iss_src       <= SRC_I2C_PF;
            state         <= ISSUE;
          end
          // Losing while requesting ages the core; winning or not asking resets it
          if (!bus.core_req || core_win_c)  starve_cnt <= '0;
          else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SCW'(1);
        end
        ISSUE: begin
          state <= ((iss_src == SRC_I2C_WR) || (iss_src == SRC_CORE_WR)) ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          state <= IDLE;
          if (iss_src == SRC_CORE_RD) begin
            bus.core_rdata  <= bus.mem_rdata;
            bus.core_rvalid <= 1'b1;
          end
          if (load_c) bus.i2c_rdata <= bus.mem_rdata;
        end
        default: state <= IDLE;
      endcase

      // Write queue: cleared when the slot is won, so a strobe in that cycle is kept
      if (bus.i2c_wen) begin
        if (wr_pend && !wr_win_c) bus.wr_overrun <= 1'b1;
        wr_pend <= 1'b1;
        wr_addr <= bus.i2c_addr;
        wr_data <= bus.i2c_wdata;
      end else if (wr_win_c) begin
        wr_pend <= 1'b0;
      end

      if (addr_chg_c) last_addr <= bus.i2c_addr;

      // A new address or a write to the held address forces a (re)prefetch
      if (addr_chg_c || coh_c) pf_pend <= 1'b1;
      else if (pf_win_c)       pf_pend <= 1'b0;

      if (addr_chg_c || coh_c)     bus.i2c_rdata_valid <= 1'b0;
      else if (load_c)             bus.i2c_rdata_valid <= 1'b1;
      else if (bus.i2c_rdata_used) bus.i2c_rdata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// Directed and randomized checks of i2c_regbank_arbiter against a shadow model
// of the register bank contents.
module tb_i2c_regbank_arbiter;
  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 8;
  localparam int unsigned STARVE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_regbank_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  i2c_regbank_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Bank model: synchronous single port, plus a preload port for the bench
  logic [DW-1:0] bank [0:255];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) bank[pl_addr] <= pl_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) bank[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= bank[bus.mem_addr];
    end
  end

  logic [DW-1:0] ref_bank [0:255];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_bank[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.i2c_rdata_valid === 1'b1) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.core_gnt === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_mem(input bit we, input bit match_addr, input logic [AW-1:0] a,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.mem_en === 1'b1 && bus.mem_we === we && (!match_addr || bus.mem_addr === a)) begin
        ok = 1'b1; return;
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit            ok, seen, refetch_seen;
    int            dec, gnt_dec, bad;
    logic [AW-1:0] a;
    logic [DW-1:0] d, last_d;

    bus.i2c_rw = 1'b0; bus.i2c_addr = '0; bus.i2c_wen = 1'b0; bus.i2c_wdata = '0;
    bus.i2c_rdata_used = 1'b0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;

    // Reset held while the bank is filled with random contents
    rst = 1'b0;
    for (int i = 0; i < 256; i++) poke(AW'(i), DW'($urandom));
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_rdata_valid", bus.i2c_rdata_valid, 0);
    chk("rst_wr_overrun", bus.wr_overrun, 0);
    chk("rst_core_gnt", bus.core_gnt, 0);

    // Prefetch of address 0 follows reset release
    rst = 1'b1;
    step();
    chk("boot_pf_en", bus.mem_en, 1);
    chk("boot_pf_we", bus.mem_we, 0);
    chk("boot_pf_addr", bus.mem_addr, 0);
    step();
    chk("boot_pf_single", bus.mem_en, 0);
    chk("boot_valid_early", bus.i2c_rdata_valid, 0);
    step();
    chk("boot_valid", bus.i2c_rdata_valid, 1);
    chk("boot_rdata", bus.i2c_rdata, ref_bank[0]);

    // I2C write: strobe in T, bank write in T+2, then re-prefetch returns the new byte
    repeat (3) step();
    bus.i2c_addr = 8'h10; bus.i2c_wen = 1'b1; bus.i2c_wdata = 8'hA5;
    ref_bank[8'h10] = 8'hA5;
    step();
    bus.i2c_wen = 1'b0;
    chk("wr_t1_idle", bus.mem_en, 0);
    step();
    chk("wr_en", bus.mem_en, 1);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_addr", bus.mem_addr, 8'h10);
    chk("wr_wdata", bus.mem_wdata, 8'hA5);
    step();
    wait_valid(ok);
    chk("wr_readback_valid", ok, 1);
    chk("wr_readback", bus.i2c_rdata, 8'hA5);

    // Auto-increment read with consume pulses
    poke(8'h20, 8'h11); poke(8'h21, 8'h22); poke(8'h22, 8'h33);
    for (int k = 0; k < 3; k++) begin
      bus.i2c_addr = AW'(8'h20 + k);
      repeat (50) step();
      chk($sformatf("autoinc_valid_%0d", k), bus.i2c_rdata_valid, 1);
      chk($sformatf("autoinc_rdata_%0d", k), bus.i2c_rdata, ref_bank[8'h20 + k]);
      bus.i2c_rdata_used = 1'b1;
      step();
      bus.i2c_rdata_used = 1'b0;
      chk($sformatf("autoinc_used_%0d", k), bus.i2c_rdata_valid, 0);
    end

    // Starvation: writes every cycle, core must win on decision STARVE+1
    bus.i2c_addr = 8'h30;
    step();
    wait_valid(ok);
    repeat (5) step();
    last_d = DW'($urandom);
    bus.i2c_wen = 1'b1; bus.i2c_wdata = last_d;
    step();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h40; bus.core_wdata = 8'h77;
    ref_bank[8'h40] = 8'h77;
    dec = 0; seen = 1'b0; gnt_dec = 0;
    for (int i = 0; i < 16; i++) begin
      last_d = DW'($urandom);
      bus.i2c_wdata = last_d;
      step();
      if (bus.mem_en === 1'b1) dec++;
      if (bus.core_gnt === 1'b1 && !seen) begin
        seen = 1'b1; gnt_dec = dec; bus.core_req = 1'b0;
        chk("starve_gnt_addr", bus.mem_addr, 8'h40);
        chk("starve_gnt_we", bus.mem_we, 1);
        chk("starve_gnt_wdata", bus.mem_wdata, 8'h77);
      end
    end
    bus.i2c_wen = 1'b0;
    bus.core_req = 1'b0;
    ref_bank[8'h30] = last_d;
    chk("starve_gnt_seen", seen, 1);
    chk("starve_gnt_decision", gnt_dec, STARVE + 1);
    chk("starve_overrun", bus.wr_overrun, 1);
    repeat (10) step();
    wait_valid(ok);
    chk("starve_final_valid", ok, 1);
    chk("starve_final_rdata", bus.i2c_rdata, last_d);

    // Core read latency
    poke(8'h05, 8'h5C);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h05;
    wait_gnt(ok);
    bus.core_req = 1'b0;
    chk("cr_gnt", ok, 1);
    chk("cr_mem_addr", bus.mem_addr, 8'h05);
    step();
    chk("cr_rvalid_n1", bus.core_rvalid, 0);
    step();
    chk("cr_rvalid_n2", bus.core_rvalid, 1);
    chk("cr_rdata", bus.core_rdata, 8'h5C);

    // Address change while the prefetch is in CAPTURE
    repeat (5) step();
    bus.i2c_addr = 8'h60;
    wait_mem(1'b0, 1'b1, 8'h60, ok);
    chk("pfchg_issue_seen", ok, 1);
    step();
    bus.i2c_addr = 8'h61;
    step();
    chk("pfchg_stale_dropped", bus.i2c_rdata_valid, 0);
    refetch_seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === 8'h61) refetch_seen = 1'b1;
      if (bus.i2c_rdata_valid === 1'b1) ok = 1'b1;
      else step();
    end
    chk("pfchg_refetch_before_valid", refetch_seen, 1);
    chk("pfchg_valid", ok, 1);
    chk("pfchg_rdata", bus.i2c_rdata, ref_bank[8'h61]);

    // Reset asserted during ISSUE
    repeat (5) step();
    bus.i2c_addr = 8'h70;
    wait_mem(1'b0, 1'b1, 8'h70, ok);
    chk("rstmid_issue_seen", ok, 1);
    rst = 1'b0;
    step();
    chk("rstmid_mem_en", bus.mem_en, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    chk("rstmid_valid", bus.i2c_rdata_valid, 0);
    chk("rstmid_i2c_rdata", bus.i2c_rdata, 0);
    chk("rstmid_overrun", bus.wr_overrun, 0);
    chk("rstmid_core_rdata", bus.core_rdata, 0);
    rst = 1'b1;
    step();
    wait_valid(ok);
    chk("rstmid_recover_valid", ok, 1);
    chk("rstmid_recover_rdata", bus.i2c_rdata, ref_bank[8'h70]);

    // Randomized mix of I2C writes, I2C reads and core accesses
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = AW'($urandom); d = DW'($urandom);
          bus.i2c_addr = a; bus.i2c_wen = 1'b1; bus.i2c_wdata = d;
          ref_bank[a] = d;
          step();
          bus.i2c_wen = 1'b0;
          wait_mem(1'b1, 1'b1, a, ok);
          chk($sformatf("rnd%0d_wr_issue", it), ok, 1);
          step();
          wait_valid(ok);
          chk($sformatf("rnd%0d_wr_rdata", it), bus.i2c_rdata, d);
        end
        1: begin
          a = AW'($urandom);
          bus.i2c_addr = a;
          step();
          wait_valid(ok);
          chk($sformatf("rnd%0d_rd_rdata", it), bus.i2c_rdata, ref_bank[a]);
        end
        default: begin
          a = AW'($urandom); d = DW'($urandom);
          bus.core_we = 1'($urandom_range(0, 1));
          if (bus.core_we) while (a == bus.i2c_addr) a = a + AW'(1);
          bus.core_addr = a; bus.core_wdata = d; bus.core_req = 1'b1;
          wait_gnt(ok);
          bus.core_req = 1'b0;
          chk($sformatf("rnd%0d_core_gnt", it), ok, 1);
          if (bus.core_we) begin
            ref_bank[a] = d;
            repeat (2) step();
          end else begin
            repeat (2) step();
            chk($sformatf("rnd%0d_core_rdata", it), bus.core_rdata, ref_bank[a]);
          end
        end
      endcase
    end

    repeat (5) step();
    bad = 0;
    for (int i = 0; i < 256; i++) if (bank[i] !== ref_bank[i]) bad++;
    chk("bank_contents", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
